// File: rtl/pipe_hazard_unit.sv
// ID-stage hazard/forwarding control with a one-entry multiply/divide scoreboard.
// Optional stall-cycle counter is built only when HAZ_STALL_CNT_EN is defined.
module pipe_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int NRD    = 2,
    parameter int MD_LAT = 4
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [NRD*REG_AW-1:0] d_rs,
    input  logic [NRD-1:0]        d_ruse,
    input  logic [REG_AW-1:0]     d_wn,
    input  logic                  d_wreg,
    input  logic                  d_md,
    input  logic                  d_flush,
    input  logic [REG_AW-1:0]     e_rn,
    input  logic [REG_AW-1:0]     m_rn,
    input  logic                  e_wreg,
    input  logic                  m_wreg,
    input  logic                  e_m2reg,
    input  logic                  m_m2reg,
    output logic [NRD*2-1:0]      fwd,
    output logic                  wpcir,
    output logic                  dbubble,
    output logic                  md_busy,
    output logic [REG_AW-1:0]     md_rn,
    output logic                  md_wb,
    output logic [31:0]           stall_cnt
);

    localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [REG_AW-1:0] md_rn_q, md_rn_d;

    logic              e_live, m_live, md_live;
    logic [NRD-1:0]    e_hit, m_hit, md_hit;
    logic              loaduse, md_raw, md_waw, md_struct;
    logic              issue;

    // Register 0 is hardwired, so a write to it is never a producer.
    assign e_live  = e_wreg & (|e_rn);
    assign m_live  = m_wreg & (|m_rn);
    assign md_live = md_busy & (|md_rn_q);

    always_comb begin
        e_hit  = '0;
        m_hit  = '0;
        md_hit = '0;
        for (int i = 0; i < NRD; i++) begin
            e_hit[i]  = d_ruse[i] & e_live  & (d_rs[i*REG_AW +: REG_AW] == e_rn);
            m_hit[i]  = d_ruse[i] & m_live  & (d_rs[i*REG_AW +: REG_AW] == m_rn);
            md_hit[i] = d_ruse[i] & md_live & (d_rs[i*REG_AW +: REG_AW] == md_rn_q);
        end
    end

    // Youngest producer wins; a load still in E cannot forward and falls through.
    always_comb begin
        fwd = '0;
        for (int i = 0; i < NRD; i++) begin
            if (e_hit[i] & ~e_m2reg)
                fwd[2*i +: 2] = 2'b01;
            else if (m_hit[i] & ~m_m2reg)
                fwd[2*i +: 2] = 2'b10;
            else if (m_hit[i])
                fwd[2*i +: 2] = 2'b11;
            else
                fwd[2*i +: 2] = 2'b00;
        end
    end

    assign loaduse   = (|e_hit) & e_m2reg;
    assign md_raw    = |md_hit;
    assign md_waw    = md_live & d_wreg & (d_wn == md_rn_q);
    assign md_struct = md_busy & d_md;

    assign wpcir   = ~(loaduse | md_raw | md_waw | md_struct);
    assign dbubble = ~wpcir | d_flush;

    assign md_busy = (state_q == ST_BUSY);
    assign md_wb   = md_busy & (cnt_q == '0);
    assign md_rn   = md_rn_q;
    assign issue   = d_md & d_wreg & wpcir & ~d_flush;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        md_rn_d = md_rn_q;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    state_d = ST_BUSY;
                    cnt_d   = CW'(MD_LAT - 1);
                    md_rn_d = d_wn;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0)
                    state_d = ST_IDLE;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            md_rn_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            md_rn_q <= md_rn_d;
        end
    end

`ifdef HAZ_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            stall_cnt_q <= '0;
        else if (!wpcir)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit with a cycle-indexed reference model.
module tb_pipe_hazard_unit;

    localparam int AW     = 5;
    localparam int NRD    = 2;
    localparam int MD_LAT = 4;

    logic              clock = 1'b0;
    logic              resetn;
    logic [NRD*AW-1:0] d_rs;
    logic [NRD-1:0]    d_ruse;
    logic [AW-1:0]     d_wn;
    logic              d_wreg, d_md, d_flush;
    logic [AW-1:0]     e_rn, m_rn;
    logic              e_wreg, m_wreg, e_m2reg, m_m2reg;
    logic [NRD*2-1:0]  fwd;
    logic              wpcir, dbubble, md_busy, md_wb;
    logic [AW-1:0]     md_rn;
    logic [31:0]       stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_hazard_unit #(.REG_AW(AW), .NRD(NRD), .MD_LAT(MD_LAT)) dut (
        .clock(clock), .resetn(resetn), .d_rs(d_rs), .d_ruse(d_ruse),
        .d_wn(d_wn), .d_wreg(d_wreg), .d_md(d_md), .d_flush(d_flush),
        .e_rn(e_rn), .m_rn(m_rn), .e_wreg(e_wreg), .m_wreg(m_wreg),
        .e_m2reg(e_m2reg), .m_m2reg(m_m2reg), .fwd(fwd), .wpcir(wpcir),
        .dbubble(dbubble), .md_busy(md_busy), .md_rn(md_rn), .md_wb(md_wb),
        .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: multiply/divide occupancy expressed as a window of cycle numbers.
    int          cyc = 0;
    int          issue_cyc = 0;
    bit          issue_valid = 0;
    logic [AW-1:0] rn_m = '0;
    logic [31:0] scnt_m = '0;

    function automatic void model_eval(output logic [NRD*2-1:0] f, output logic w,
                                       output logic db, output logic b, output logic wb);
        bit lu, raw, waw, st;
        lu = 0; raw = 0;
        b  = issue_valid && (cyc > issue_cyc) && (cyc <= issue_cyc + MD_LAT);
        wb = issue_valid && (cyc == issue_cyc + MD_LAT);
        f  = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0] rs;
            bit me, mm;
            rs = d_rs[i*AW +: AW];
            me = d_ruse[i] && e_wreg && (e_rn != 0) && (e_rn == rs);
            mm = d_ruse[i] && m_wreg && (m_rn != 0) && (m_rn == rs);
            if (me && !e_m2reg)      f[2*i +: 2] = 2'd1;
            else if (mm && !m_m2reg) f[2*i +: 2] = 2'd2;
            else if (mm)             f[2*i +: 2] = 2'd3;
            if (me && e_m2reg) lu = 1;
            if (b && d_ruse[i] && rn_m != 0 && rs == rn_m) raw = 1;
        end
        waw = b && d_wreg && rn_m != 0 && d_wn == rn_m;
        st  = b && d_md;
        w   = !(lu || raw || waw || st);
        db  = !w || d_flush;
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            issue_valid = 0;
            rn_m        = '0;
            scnt_m      = '0;
        end else begin
            logic [NRD*2-1:0] f;
            logic w, db, b, wb;
            model_eval(f, w, db, b, wb);
            if (!w) scnt_m = scnt_m + 1;
            if (d_md && d_wreg && w && !d_flush) begin
                issue_valid = 1;
                issue_cyc   = cyc;
                rn_m        = d_wn;
            end
            cyc = cyc + 1;
        end
    end

    always @(negedge clock) begin
        logic [NRD*2-1:0] f;
        logic w, db, b, wb;
        model_eval(f, w, db, b, wb);
        chk("m_fwd", 32'(fwd), 32'(f));
        chk("m_wpcir", 32'(wpcir), 32'(w));
        chk("m_dbubble", 32'(dbubble), 32'(db));
        chk("m_md_busy", 32'(md_busy), 32'(b));
        chk("m_md_wb", 32'(md_wb), 32'(wb));
        if (b) chk("m_md_rn", 32'(md_rn), 32'(rn_m));
`ifdef HAZ_STALL_CNT_EN
        chk("m_stall_cnt", stall_cnt, scnt_m);
`else
        chk("m_stall_cnt", stall_cnt, 32'd0);
`endif
    end

    task automatic idle();
        d_rs = '0; d_ruse = '0; d_wn = '0; d_wreg = 0; d_md = 0; d_flush = 0;
        e_rn = '0; m_rn = '0; e_wreg = 0; m_wreg = 0; e_m2reg = 0; m_m2reg = 0;
    endtask

    task automatic set_rs(input int p, input logic [AW-1:0] v);
        d_rs[p*AW +: AW] = v;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    initial begin
        idle();
        resetn = 0;
        repeat (2) at_neg();
        chk("rst_fwd", 32'(fwd), 0);
        chk("rst_wpcir", 32'(wpcir), 1);
        chk("rst_dbubble", 32'(dbubble), 0);
        chk("rst_busy", 32'(md_busy), 0);
        chk("rst_wb", 32'(md_wb), 0);
        chk("rst_md_rn", 32'(md_rn), 0);
        chk("rst_stall_cnt", stall_cnt, 0);

        // Forwarding priority on port 0
        step(); resetn = 1;
        e_rn = 5; e_wreg = 1; m_rn = 5; m_wreg = 1; set_rs(0, 5); d_ruse = 2'b01;
        at_neg(); chk("fwd_e", 32'(fwd[1:0]), 1); chk("fwd_e_wpcir", 32'(wpcir), 1);
        step(); e_wreg = 0;
        at_neg(); chk("fwd_m", 32'(fwd[1:0]), 2);
        step(); m_m2reg = 1;
        at_neg(); chk("fwd_mmo", 32'(fwd[1:0]), 3); chk("fwd_mmo_wpcir", 32'(wpcir), 1);

        // Register 0 never forwards or stalls
        step(); idle(); e_rn = 0; e_wreg = 1; set_rs(1, 0); d_ruse = 2'b10;
        at_neg(); chk("r0_fwd", 32'(fwd), 0); chk("r0_wpcir", 32'(wpcir), 1);
        step(); e_m2reg = 1;
        at_neg(); chk("r0_load_wpcir", 32'(wpcir), 1); chk("r0_load_db", 32'(dbubble), 0);

        step(); idle(); resetn = 0; #1; resetn = 1;

        // Three load-use stalls on port 1
        repeat (3) begin
            step(); idle(); e_rn = 8; e_wreg = 1; e_m2reg = 1; set_rs(1, 8); d_ruse = 2'b10;
            at_neg(); chk("lu_wpcir", 32'(wpcir), 0); chk("lu_db", 32'(dbubble), 1);
            step(); e_rn = 0; e_wreg = 0; e_m2reg = 0; m_rn = 8; m_wreg = 1; m_m2reg = 1;
            at_neg(); chk("lu_fwd", 32'(fwd[3:2]), 3); chk("lu_next_wpcir", 32'(wpcir), 1);
            chk("lu_next_db", 32'(dbubble), 0);
        end
`ifdef HAZ_STALL_CNT_EN
        chk("lu_stall_cnt", stall_cnt, 3);
`endif

        // MD RAW: mul r9 then a reader of r9
        step(); idle(); d_md = 1; d_wreg = 1; d_wn = 9;
        at_neg(); chk("md_iss_wpcir", 32'(wpcir), 1); chk("md_iss_busy", 32'(md_busy), 0);
        step(); d_md = 0; d_wn = 10; set_rs(0, 9); d_ruse = 2'b01;
        for (int k = 1; k <= MD_LAT; k++) begin
            at_neg();
            chk("raw_wpcir", 32'(wpcir), 0);
            chk("raw_busy", 32'(md_busy), 1);
            chk("raw_md_rn", 32'(md_rn), 9);
            chk("raw_wb", 32'(md_wb), (k == MD_LAT) ? 1 : 0);
            step();
        end
        at_neg(); chk("raw_adv_wpcir", 32'(wpcir), 1); chk("raw_adv_fwd", 32'(fwd), 0);
        chk("raw_adv_busy", 32'(md_busy), 0);

        // Back-to-back mul waits on the structural hazard
        step(); idle(); d_md = 1; d_wreg = 1; d_wn = 9;
        at_neg();
        step(); d_wn = 11;
        for (int k = 1; k <= MD_LAT; k++) begin
            at_neg(); chk("st_wpcir", 32'(wpcir), 0); chk("st_md_rn", 32'(md_rn), 9);
            step();
        end
        at_neg(); chk("st_adv_wpcir", 32'(wpcir), 1);
        step(); idle();
        at_neg(); chk("st2_busy", 32'(md_busy), 1); chk("st2_md_rn", 32'(md_rn), 11);
        repeat (MD_LAT) step();

        // WAW against outstanding r9
        idle(); d_md = 1; d_wreg = 1; d_wn = 9;
        at_neg();
        step(); d_md = 0; d_wreg = 1; d_wn = 9;
        at_neg(); chk("waw_wpcir", 32'(wpcir), 0); chk("waw_db", 32'(dbubble), 1);
        repeat (MD_LAT) step();
        at_neg(); chk("waw_adv_wpcir", 32'(wpcir), 1);

        // Flushed mul is never issued
        step(); idle(); d_md = 1; d_wreg = 1; d_wn = 12; d_flush = 1;
        at_neg(); chk("fl_db", 32'(dbubble), 1); chk("fl_wpcir", 32'(wpcir), 1);
        step(); idle();
        at_neg(); chk("fl_busy", 32'(md_busy), 0);

        // Reset while busy abandons the op
        step(); d_md = 1; d_wreg = 1; d_wn = 13;
        at_neg();
        step(); idle();
        at_neg(); chk("rb_busy_pre", 32'(md_busy), 1);
        step(); resetn = 0; #1;
        chk("rb_busy", 32'(md_busy), 0); chk("rb_wb", 32'(md_wb), 0); chk("rb_md_rn", 32'(md_rn), 0);
        step(); step(); resetn = 1;
        repeat (MD_LAT + 2) begin
            at_neg(); chk("rb_no_wb", 32'(md_wb), 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard and forwarding controller for the ID stage of the five-stage pipelined CPU. It generalises per-operand forwarding to NRD read ports and adds a one-entry scoreboard for a multi-cycle multiply/divide unit. It drives forward-mux selects, the PC/IF-ID write enable and the ID bubble, and stalls on load-use, multiply/divide RAW, WAW and structural hazards. It sits beside the register file in ID and is fed by the E and M stage pipeline registers.

## Interface
- REG_AW, 5, register address width
- NRD, 2, number of ID read ports (1..4)
- MD_LAT, 4, multiply/divide latency in cycles (2..15)

- clock  in  1  pipeline clock, rising edge
- resetn  in  1  asynchronous active-low reset
- d_rs  in  NRD*REG_AW  ID read addresses, port i at [i*REG_AW +: REG_AW]
- d_ruse  in  NRD  port i actually reads its register
- d_wn  in  REG_AW  ID destination register
- d_wreg  in  1  ID instruction writes a register
- d_md  in  1  ID instruction is a multiply/divide op
- d_flush  in  1  ID instruction is squashed (taken branch/jump redirect)
- e_rn, m_rn  in  REG_AW  E and M destination registers
- e_wreg, m_wreg  in  1  E and M write enables
- e_m2reg, m_m2reg  in  1  E and M hold a load
- fwd  out  NRD*2  per-port select: 00 regfile, 01 ealu, 10 malu, 11 mmo
- wpcir  out  1  1 = PC and IF/ID advance
- dbubble  out  1  1 = zero ID control signals into E
- md_busy  out  1  scoreboard entry valid
- md_rn  out  REG_AW  destination of the outstanding multiply/divide
- md_wb  out  1  one-cycle multiply/divide writeback strobe
- stall_cnt  out  32  stall-cycle counter (macro only)

## Operation
- A port matches a stage when d_ruse[i], the stage's wreg is set, its rn is nonzero, and its rn equals the port address. Register 0 never forwards or stalls.
- fwd per port, first match wins:
  - E match with ~e_m2reg gives 01.
  - Otherwise M match with ~m_m2reg gives 10.
  - Otherwise M match with m_m2reg gives 11.
  - Otherwise 00.
- Stall conditions:
  - loaduse: any port matches E and e_m2reg is set.
  - md_raw: md_busy, and any port with d_ruse reads md_rn (md_rn nonzero).
  - md_waw: md_busy, d_wreg, and d_wn == md_rn (nonzero).
  - md_struct: md_busy and d_md.
- Combinational outputs:
  - wpcir = ~(loaduse | md_raw | md_waw | md_struct).
  - dbubble = ~wpcir | d_flush.
- Scoreboard FSM, two states:
  - IDLE to BUSY on an edge where d_md & d_wreg & wpcir & ~d_flush. Load md_rn = d_wn and cnt = MD_LAT-1.
  - In BUSY, cnt decrements each edge. md_wb = md_busy & (cnt == 0).
  - BUSY to IDLE on the edge where md_wb is high. md_rn is held until the next issue.
  - Because md_struct stalls through the md_wb cycle, a new issue is never accepted in that cycle.
- Reset, asynchronous: state IDLE, cnt 0, md_rn 0, md_wb 0, md_busy 0, stall_cnt 0. With idle E/M inputs this gives wpcir=1, dbubble=0 and fwd all 00.
- Reset during BUSY abandons the operation; no md_wb is emitted.

## Timing
- fwd, wpcir and dbubble are combinational and have zero latency.
- The scoreboard updates on the rising edge.
- Issue accepted at edge t: md_busy is high for cycles t+1 .. t+MD_LAT, and md_wb is high only in cycle t+MD_LAT.
- A dependent read stalls through cycle t+MD_LAT and advances at cycle t+MD_LAT+1, reading the register file (00).
- Load-use: exactly one stall cycle. The next cycle forwards 11 from M.
- Simultaneous loaduse and md_raw: a single stall. wpcir stays low while either condition holds.

## Configuration
- HAZ_STALL_CNT_EN defined: stall_cnt increments (wrapping mod 2^32) on every edge where wpcir=0. Flush-only bubbles are not counted.
- HAZ_STALL_CNT_EN undefined: stall_cnt is tied to 0 and no counter flops exist.

## Test plan
- Forwarding priority: E and M both write r5 (no loads), port 0 reads r5 -> fwd[1:0]=01, wpcir=1. With e_wreg=0 -> 10. With m_m2reg=1 -> 11.
- Register 0: E writes r0, port 1 reads r0 -> fwd[3:2]=00, wpcir=1. Load to r0 in E gives no stall.
- Load-use: E is a load to r8, port 1 reads r8 -> wpcir=0, dbubble=1 for exactly one cycle, then fwd[3:2]=11.
- MD RAW, MD_LAT=4: mul to r9 issued at edge t, next instruction reads r9 -> wpcir=0 for cycles t+1..t+4, md_wb=1 at t+4, advance at t+5 with fwd 00. A second mul at t+1 is also stalled until t+5.
- WAW and flush: busy on r9, ID addu to r9 -> stall. A flushed mul is not issued (md_busy stays 0) and gives dbubble=1.
- Reset/counter: assert resetn=0 mid-BUSY -> md_busy=0 with no md_wb. With HAZ_STALL_CNT_EN, 3 load-use stalls -> stall_cnt=3.
